// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 13;
  localparam int DATA_W_DEF  = 8;
  localparam int PORT_CPU    = 0;
  localparam int PORT_LOADER = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake plus memory-side bus of the two-port memory arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // Handshake: a port holds req (with we/addr/wdata stable) until its gnt is
  // seen high in the same cycle; the access is then owned by the arbiter and
  // ends with a one-cycle ack (rdata valid with the ack of a read).
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_command;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_command,
    output gnt, ack, rdata, mem_address, mem_write_data, mem_read, mem_write
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_command,
    input  gnt, ack, rdata, mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way request selector. MEM_ARB_ROUND_ROBIN_EN selects round robin
// (with last-grant pointer); otherwise port 0 has fixed priority.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer starts at the loader so the CPU wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_q <= 1'(PORT_LOADER);
    else if (|gnt) last_q <= gnt[1];
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and loader accesses onto the single-ported program/data
// memory. Optional round robin via MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output state_t              state_dbg
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        ack_q;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              take;
  logic              done;

  // Grants only in IDLE and never while reset is held.
  assign arb_en = (state == IDLE) && !rst;
  assign take   = |gnt;
  assign done   = (state == ACCESS) && (cnt == '0);

  rr_arbiter_2 u_arb (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk (clk),
    .rst (rst),
`endif
    .en  (arb_en),
    .req (bus.req),
    .gnt (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state)
      IDLE:   if (take) state_next = ACCESS;
      ACCESS: begin
        bus.mem_read  = !we_q;
        bus.mem_write = we_q;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 2'b00;
    end else begin
      ack_q <= 2'b00;
      if (take) begin
        owner   <= gnt[1];
        we_q    <= gnt[1] ? bus.we[1] : bus.we[0];
        addr_q  <= gnt[1] ? bus.addr1 : bus.addr0;
        wdata_q <= gnt[1] ? bus.wdata1 : bus.wdata0;
        cnt     <= CNT_LOAD;
      end else if (state == ACCESS) begin
        if (cnt == '0) begin
          ack_q <= owner ? 2'b10 : 2'b01;
          if (!we_q) rdata_q <= bus.mem_command;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  // Address/data come straight from the owner registers so they hold between accesses.
  assign bus.gnt            = gnt;
  assign bus.ack            = ack_q;
  assign bus.rdata          = rdata_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign state_dbg          = state;

endmodule
